// File: rtl/univ_shift_reg_if.sv
// Bus bundle for the universal shift register: control/data from the master
// and register contents and status back from the slave.
interface univ_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
);
  logic [WIDTH-1:0] d;
  logic             load;
  logic             start;
  logic             dir;
  logic             rot;
  logic [CNT_W-1:0] cnt;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output d, load, start, dir, rot, cnt, sin,
    input  q, sout, busy, done
  );

  modport slave (
    input  d, load, start, dir, rot, cnt, sin,
    output q, sout, busy, done
  );
endinterface

// File: rtl/univ_shift_reg.sv
// WIDTH-bit register with parallel load and a multi-cycle shift/rotate engine
// that reports progress through busy and a one-cycle done pulse.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic            clk,
  input logic            rst,
  univ_shift_reg_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} stateT;

  stateT            r_state;
  logic [WIDTH-1:0] r_q;
  logic             r_sout;
  logic             r_busy;
  logic             r_done;
  logic             r_dir;
  logic             r_rot;
  logic [CNT_W-1:0] r_remaining;

  logic [CNT_W-1:0] w_clamped;
  logic             w_out;
  logic             w_in;
  logic [WIDTH-1:0] w_shifted;

  // Requests longer than the register are clamped to a full-width pass.
  assign w_clamped = (bus.cnt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : bus.cnt;

  assign w_out     = r_dir ? r_q[0] : r_q[WIDTH-1];
  assign w_in      = r_rot ? w_out : bus.sin;
  assign w_shifted = r_dir ? {w_in, r_q[WIDTH-1:1]} : {r_q[WIDTH-2:0], w_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_q         <= '0;
      r_sout      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dir       <= 1'b0;
      r_rot       <= 1'b0;
      r_remaining <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.load) begin
            r_q <= bus.d;
          end else if (bus.start) begin
            r_dir       <= bus.dir;
            r_rot       <= bus.rot;
            r_remaining <= w_clamped;
            if (w_clamped != '0) begin
              r_state <= SHIFT;
              r_busy  <= 1'b1;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        SHIFT: begin
          r_q         <= w_shifted;
          r_sout      <= w_out;
          r_remaining <= r_remaining - 1'b1;
          if (r_remaining == CNT_W'(1)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.q    = r_q;
  assign bus.sout = r_sout;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
endmodule
